// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register sequencer: S select codes,
// shift modes and the controller state type.
package shift_pkg;
  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ROT = 2'b01;
  localparam logic [1:0] MODE_ARI = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/shift_sequencer_if.sv
// Request/status handshake plus the S/D/Sr/Sl/Q bus to the shift register.
interface shift_sequencer_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic             fill;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic             abort;
  logic [WIDTH-1:0] q_fb;
  logic [1:0]       S;
  logic [WIDTH-1:0] D;
  logic             Sr;
  logic             Sl;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (output start, dir, mode, fill, count, data_in, abort, q_fb,
                  input  S, D, Sr, Sl, ready, busy, done);
  modport slave  (input  start, dir, mode, fill, count, data_in, abort, q_fb,
                  output S, D, Sr, Sl, ready, busy, done);
endinterface

// File: rtl/serial_fill_sel.sv
// Picks the serial bit fed into the register while shifting; both serial
// inputs are forced low outside the shift phase.
module serial_fill_sel
  import shift_pkg::*;
(
  input  logic       shift_en,
  input  logic       dir,
  input  logic [1:0] mode,
  input  logic       fill,
  input  logic       q_lsb,
  input  logic       q_msb,
  output logic       sr,
  output logic       sl
);
  always_comb begin
    sr = 1'b0;
    sl = 1'b0;
    if (shift_en) begin
      if (!dir) begin
        case (mode)
          MODE_ROT: sr = q_lsb;
          MODE_ARI: sr = q_msb;
          default:  sr = fill;
        endcase
      end else begin
        // Arithmetic left is a zero fill, same as a logical left with fill=0.
        case (mode)
          MODE_ROT: sl = q_msb;
          MODE_ARI: sl = 1'b0;
          default:  sl = fill;
        endcase
      end
    end
  end
endmodule

// File: rtl/shift_sequencer.sv
// Control stage for an 8-bit universal shift register: loads a byte, then
// steps it N places using Q feedback for rotate/arithmetic fills.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic            CP,
  input  logic            CR_,
  shift_sequencer_if.slave bus
);
  localparam int REM_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             shift_en;

  always_ff @(posedge CP or negedge CR_) begin
    if (!CR_) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      mode_q  <= MODE_LOG;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    mode_d  = mode_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          mode_d  = bus.mode;
          fill_d  = bus.fill;
          data_d  = bus.data_in;
          rem_d   = (int'(bus.count) > WIDTH) ? REM_W'(WIDTH) : REM_W'(bus.count);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.abort)          state_d = ST_IDLE;
        else if (rem_q != '0)   state_d = ST_SHIFT;
        else                    state_d = ST_DONE;
      end
      ST_SHIFT: begin
        // An aborted step still shifts on this edge since S is already set.
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.S = S_HOLD;
    case (state_q)
      ST_LOAD:  bus.S = S_LOAD;
      ST_SHIFT: bus.S = dir_q ? S_LEFT : S_RIGHT;
      default:  bus.S = S_HOLD;
    endcase
  end

  assign bus.D     = data_q;
  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign shift_en  = (state_q == ST_SHIFT);

  serial_fill_sel u_sel (
    .shift_en (shift_en),
    .dir      (dir_q),
    .mode     (mode_q),
    .fill     (fill_q),
    .q_lsb    (bus.q_fb[0]),
    .q_msb    (bus.q_fb[WIDTH-1]),
    .sr       (bus.Sr),
    .sl       (bus.Sl)
  );
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Upstream control stage for the 8-bit universal shift register (mode select S: 00 hold, 01 right, 10 left, 11 parallel load; serial inputs Sr/Sl; parallel input D; output Q).
- Accepts a byte-plus-command request and drives S/D/Sr/Sl cycle by cycle. The register loads the byte, then shifts it N places in the requested direction and mode.
- Reads the register's Q back, so it supports logical, rotate and arithmetic shifts.
- Reports completion with a one-cycle pulse.

Parameters:
- WIDTH, 8, data width; must match the shift register.
- CNT_W, 4, width of the shift-count field.

Ports:
- CP  input  1  clock; all state updates on rising edge.
- CR_  input  1  asynchronous active-low reset; tie to the same net as the shift register's CR_.
- start  input  1  request strobe; accepted only when ready=1.
- dir  input  1  0 = right (S=01), 1 = left (S=10).
- mode  input  2  00 logical fill, 01 rotate, 10 arithmetic, 11 reserved (treated as 00).
- fill  input  1  serial fill bit for logical mode.
- count  input  CNT_W  number of shift steps; values >WIDTH clamp to WIDTH.
- data_in  input  WIDTH  byte to load.
- abort  input  1  cancels an in-progress operation.
- q_fb  input  WIDTH  Q of the shift register.
- S  output  2  mode select to the shift register.
- D  output  WIDTH  parallel data to the shift register.
- Sr  output  1  right-shift serial input.
- Sl  output  1  left-shift serial input.
- ready  output  1  high in IDLE only.
- busy  output  1  high in LOAD, SHIFT and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock/reset: one clock CP; reset CR_ is asynchronous and active-low.
- Reset values: state=IDLE, S=00, D=0, Sr=0, Sl=0, ready=1, busy=0, done=0, all latched fields = 0. Reset mid-operation returns to IDLE immediately and does not wait for an edge.
- FSM is Moore. S, D, ready, busy and done decode from registered state. Sr/Sl are combinational from latched mode/dir/fill and q_fb.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: S=00. On a rising edge with start=1, latch dir, mode, fill, data_in and count (clamped to WIDTH) into remaining; go to LOAD.
- LOAD: S=11, D=latched data, so the register captures the data on this edge.
  - Next state is SHIFT if remaining>0, else DONE.
- SHIFT: S=01 if dir=0, S=10 if dir=1.
  - Each edge decrements remaining. When remaining==1 at the edge, go to DONE.
  - Exactly `count` shift edges occur.
- DONE: S=00, done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; done is high during the cycle after edge k+1+count, i.e. count+2 cycles after acceptance. Register Q holds the final result from that same cycle.
- Serial bit selection, valid in SHIFT only; Sr=Sl=0 in all other states:
  - right logical: Sr=fill
  - right rotate: Sr=q_fb[0]
  - right arithmetic: Sr=q_fb[WIDTH-1]
  - left logical: Sl=fill
  - left rotate: Sl=q_fb[WIDTH-1]
  - left arithmetic: Sl=0
- start while busy is ignored; no queuing. start coincident with the done cycle is also ignored.
- abort=1 in LOAD or SHIFT: next state IDLE with no done pulse. The register keeps its partially shifted value because S=00 from the following cycle.
- abort in IDLE or DONE has no effect. abort and start together in IDLE: start wins.
- D outside LOAD holds the last latched data (don't-care to the register).

Decomposition:
- Shared package shift_pkg holds:
  - S encodings: S_HOLD=2'b00, S_RIGHT=2'b01, S_LEFT=2'b10, S_LOAD=2'b11.
  - Mode encodings: MODE_LOG, MODE_ROT, MODE_ARI.
  - The state enum.
- One natural sub-module, serial_fill_sel: the combinational Sr/Sl selector. The FSM and counter stay in shift_sequencer.

Test Plan:
- Instantiate with the shift register, q_fb=Q.
- data_in=0xB4, dir=0, mode=00, fill=0, count=3 -> S sequence 11,01,01,01,00; done exactly 5 cycles after acceptance; Q=0x16.
- data_in=0x81, dir=1, mode=01, count=1 -> Q=0x03, done one cycle; then data_in=0x80, dir=0, mode=10, count=2 -> Q=0xE0.
- data_in=0x00, dir=1, mode=00, fill=1, count=12 -> clamps to 8 shifts; Q=0xFF; exactly 8 cycles with S=10.
- count=0, data_in=0x5A -> LOAD then DONE; Q=0x5A; done 2 cycles after acceptance; start pulsed during LOAD ignored, ready stays 0.
- data_in=0xF0, dir=0, mode=00, fill=0, count=6, abort after 2 shifts -> Q=0x3C held; no done; ready=1 next cycle.
- CR_ asserted asynchronously mid-SHIFT -> S=00, busy=0, ready=1 without waiting for an edge; Q=0x00; fresh start afterwards completes normally.
